game_flow_controller: RTL and testbench

- Parametrised top-level game sequencer. Successor to the single-level START/LEVEL/WIN/GAME_OVER flow.
- Adds multi-level progression, a lives counter, a debounced start button, per-level restart pulses and an end-screen hold-off before restart.
- Sits between the VGA signal generator / screen drawers and the board I/O. Drives the screen-select mux and the active level's reset.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_flow_controller_button_debouncer.sv | 31 +++
 rtl/game_flow_controller.sv | 86 ++++++++
 tb/tb_game_flow_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game states, screen-select encodings and display helpers
package game_pkg;
    typedef enum logic [2:0] {
        START      = 3'd0,
        LEVEL_INIT = 3'd1,
        LEVEL      = 3'd2,
        WIN        = 3'd3,
        GAME_OVER  = 3'd4
    } game_state_t;

    localparam logic [1:0] SCR_START    = 2'd0;
    localparam logic [1:0] SCR_LEVEL    = 2'd1;
    localparam logic [1:0] SCR_WIN      = 2'd2;
    localparam logic [1:0] SCR_GAMEOVER = 2'd3;

    function automatic logic [1:0] screen_of(input game_state_t s);
        return s == START ? SCR_START : s == WIN ? SCR_WIN : s == GAME_OVER ? SCR_GAMEOVER : SCR_LEVEL;
    endfunction

    function automatic logic [2:0] sat3(input int unsigned v);
        return v > 7 ? 3'd7 : v[2:0];
    endfunction
endpackage

// File: rtl/game_flow_controller_button_debouncer.sv
// button_debouncer: 2-FF synchroniser plus debounce counter for an active-low push button
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic button,
    output logic debounced,
    output logic press
);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync;
    logic [DW-1:0] cnt;
    logic          done;

    assign done = sync[1] != debounced && cnt == DW'(DEBOUNCE_CYCLES - 1);

    always_ff @(posedge vga_clock or negedge reset)
        if (!reset) begin
            sync      <= 2'b11;
            cnt       <= '0;
            debounced <= 1'b1;
            press     <= 1'b0;
        end else begin
            sync      <= {sync[0], button};
            cnt       <= (sync[1] == debounced || done) ? '0 : cnt + 1'b1;
            debounced <= done ? sync[1] : debounced;
            press     <= done & debounced;
        end
endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: multi-level game sequencer with lives, debounced start and end-screen hold-off
module game_flow_controller
    import game_pkg::*;
#(
    parameter int NUM_LEVELS      = 3,
    parameter int LIVES           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int LW              = NUM_LEVELS > 1 ? $clog2(NUM_LEVELS) : 1,
    parameter int CW              = $clog2(LIVES + 1)
) (
    input  logic          vga_clock,
    input  logic          reset,
    input  logic          start_button,
    input  logic          level_win,
    input  logic          level_lose,
    output logic [1:0]    screen_sel,
    output logic [LW-1:0] level_index,
    output logic          level_reset_n,
    output logic [CW-1:0] lives,
    output logic [9:0]    leds
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    game_state_t   state, state_n;
    logic [LW-1:0] index_n;
    logic [CW-1:0] lives_n;
    logic [HW-1:0] hold;
    logic          btn_db, press, at_end, hold_done;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .vga_clock (vga_clock),
        .reset     (reset),
        .button    (start_button),
        .debounced (btn_db),
        .press     (press)
    );

    assign at_end        = state == WIN || state == GAME_OVER;
    assign hold_done     = hold == HW'(HOLD_CYCLES);
    assign level_reset_n = state == LEVEL;

    always_comb begin
        state_n = state;
        index_n = level_index;
        lives_n = lives;
        case (state)
            START:      state_n = press ? LEVEL_INIT : START;
            LEVEL_INIT: state_n = LEVEL;
            LEVEL:
                if (level_win) begin
                    state_n = level_index == LW'(NUM_LEVELS - 1) ? WIN : LEVEL_INIT;
                    index_n = level_index == LW'(NUM_LEVELS - 1) ? level_index : level_index + 1'b1;
                end else if (level_lose) begin
                    state_n = lives <= CW'(1) ? GAME_OVER : LEVEL_INIT;
                    lives_n = lives == '0 ? lives : lives - 1'b1;
                end
            WIN, GAME_OVER:
                if (press && hold_done) begin
                    state_n = START;
                    index_n = '0;
                    lives_n = CW'(LIVES);
                end
            default:    state_n = START;
        endcase
    end

    // hold counter idles at 0 outside the end screens, so it starts from 0 on entry
    always_ff @(posedge vga_clock or negedge reset)
        if (!reset) begin
            state       <= START;
            level_index <= '0;
            lives       <= CW'(LIVES);
            hold        <= '0;
            screen_sel  <= SCR_START;
            leds        <= {1'b1, 3'b100, sat3(LIVES), 3'b000};
        end else begin
            state       <= state_n;
            level_index <= index_n;
            lives       <= lives_n;
            hold        <= at_end ? (hold_done ? hold : hold + 1'b1) : '0;
            screen_sel  <= screen_of(state_n);
            leds        <= {btn_db, state_n == START, state_n == WIN, state_n == GAME_OVER,
                            sat3(32'(lives_n)), 3'(index_n)};
        end
endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed plus randomized checks against a behavioural game model
module tb_game_flow_controller;
    localparam int NL = 2, LV = 2, DB = 4, HC = 10;
    localparam int S_START = 0, S_INIT = 1, S_PLAY = 2, S_WIN = 3, S_OVER = 4;

    logic       vga_clock = 0, reset = 1, start_button = 1, level_win = 0, level_lose = 0;
    logic [1:0] screen_sel;
    logic       level_index;
    logic       level_reset_n;
    logic [1:0] lives;
    logic [9:0] leds;
    int         checks = 0, errors = 0;
    int         ms1, ms2, mdb, mpress, mrun, mst, mli, mlv, mhold;
    logic [9:0] mleds;

    game_flow_controller #(
        .NUM_LEVELS(NL), .LIVES(LV), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC)
    ) dut (
        .vga_clock     (vga_clock),
        .reset         (reset),
        .start_button  (start_button),
        .level_win     (level_win),
        .level_lose    (level_lose),
        .screen_sel    (screen_sel),
        .level_index   (level_index),
        .level_reset_n (level_reset_n),
        .lives         (lives),
        .leds          (leds)
    );

    always #5 vga_clock = ~vga_clock;

    function automatic logic [2:0] sat(input int v);
        return v > 7 ? 3'd7 : 3'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        ms1 = 1; ms2 = 1; mdb = 1; mpress = 0; mrun = 0;
        mst = S_START; mli = 0; mlv = LV; mhold = 0;
        mleds = {1'b1, 3'b100, sat(LV), 3'd0};
    endtask

    // One clock of the game rules, using the values visible before the edge
    task automatic m_step();
        int ost = mst, opress = mpress, odb = mdb;
        case (mst)
            S_START: if (opress != 0) mst = S_INIT;
            S_INIT:  mst = S_PLAY;
            S_PLAY:
                if (level_win) begin
                    if (mli == NL - 1) mst = S_WIN;
                    else begin mli++; mst = S_INIT; end
                end else if (level_lose) begin
                    mlv--;
                    mst = mlv == 0 ? S_OVER : S_INIT;
                end
            default:
                if (opress != 0 && mhold >= HC) begin mst = S_START; mli = 0; mlv = LV; end
        endcase
        mhold = (mst == ost && (mst == S_WIN || mst == S_OVER)) ? mhold + 1 : 0;
        mpress = 0;
        mrun = (ms2 != mdb) ? mrun + 1 : 0;
        if (mrun == DB) begin mdb = ms2; mrun = 0; mpress = (mdb == 0); end
        ms2 = ms1;
        ms1 = start_button;
        mleds = {odb[0], mst == S_START, mst == S_WIN, mst == S_OVER, sat(mlv), 3'(mli)};
    endtask

    task automatic check_outputs();
        chk("screen_sel", screen_sel, mst == S_START ? 0 : mst <= S_PLAY ? 1 : mst == S_WIN ? 2 : 3);
        chk("level_index", level_index, mli);
        chk("lives", lives, mlv);
        chk("level_reset_n", level_reset_n, mst == S_PLAY);
        chk("leds", leds, mleds);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge vga_clock);
            if (reset) m_step(); else m_reset();
            #1 check_outputs();
        end
    endtask

    task automatic press_start();
        start_button = 0;
        cyc(10);
        start_button = 1;
        cyc(8);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_screen"}, screen_sel, 0);
        chk({tag, "_index"}, level_index, 0);
        chk({tag, "_lives"}, lives, 2);
        chk({tag, "_lrn"}, level_reset_n, 0);
        chk({tag, "_leds"}, leds, 10'b1_100_010_000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt = 0, bcnt = 0;
        m_reset();
        #2 reset = 0;
        #1 check_reset_values("reset");
        cyc(3);
        reset = 1;
        cyc(2);
        repeat (10) begin
            start_button = ~start_button;
            cyc(2);
        end
        cyc(8);
        chk("bounce_no_press", screen_sel, 0);
        start_button = 0;
        repeat (20) begin
            cyc(1);
            if (screen_sel == 2'd1 && level_reset_n == 1'b0) lowcnt++;
        end
        chk("init_one_cycle", lowcnt, 1);
        chk("press_screen", screen_sel, 1);
        chk("press_lrn", level_reset_n, 1);
        start_button = 1;
        cyc(8);
        level_win = 1; cyc(1); level_win = 0;
        cyc(2);
        chk("win1_index", level_index, 1);
        level_win = 1; cyc(1); level_win = 0;
        chk("win2_screen", screen_sel, 2);
        start_button = 0; cyc(8); start_button = 1; cyc(8);
        chk("early_press_ignored", screen_sel, 2);
        start_button = 0; cyc(10); start_button = 1;
        chk("restart_screen", screen_sel, 0);
        chk("restart_index", level_index, 0);
        chk("restart_lives", lives, 2);
        cyc(8);
        press_start();
        level_lose = 1; cyc(1); level_lose = 0;
        chk("lose1_lives", lives, 1);
        chk("lose1_reinit", level_reset_n, 0);
        cyc(1);
        chk("lose1_index", level_index, 0);
        level_lose = 1; cyc(1); level_lose = 0;
        chk("lose2_screen", screen_sel, 3);
        chk("lose2_lives", lives, 0);
        cyc(12);
        press_start();
        chk("over_restart", screen_sel, 0);
        press_start();
        level_win = 1; level_lose = 1; cyc(1); level_win = 0; level_lose = 0;
        cyc(1);
        chk("both_index", level_index, 1);
        chk("both_lives", lives, 2);
        level_lose = 1; cyc(1); level_lose = 0;
        chk("pre_reset_in_init", level_reset_n, 0);
        #1 reset = 0;
        #1 check_reset_values("midreset");
        m_reset();
        cyc(2);
        reset = 1;
        cyc(2);
        chk("after_reset_lrn", level_reset_n, 0);
        repeat (3000) begin
            if (bcnt == 0) begin
                start_button = 1'($urandom_range(0, 1));
                bcnt = $urandom_range(1, 14);
            end
            bcnt--;
            level_win  = $urandom_range(0, 9) == 0;
            level_lose = $urandom_range(0, 7) == 0;
            cyc(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
